// File: rtl/qu_res_station.sv
// Reservation station for the Qu execute stage: holds renamed cells, snoops the CDB, issues the lowest ready entry.
// Optional macro QU_RS_WAKEUP_BYPASS_EN lets a same-cycle CDB wakeup drive selection and the issued operand value.
package qu_res_station_pkg;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic             busy;
    logic [13:0]      op;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [31:0]      a;
  } res_st_cell_t;
endpackage

module qu_rs_entry import qu_res_station_pkg::*; #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush_i,
  input  logic             alloc_we_i,
  input  logic             issue_clr_i,
  input  res_st_cell_t     alloc_cell_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_value_i,
  output logic             busy_o,
  output logic             rdy_o,
  output res_st_cell_t     cell_o
);
  res_st_cell_t cell_q, cell_d, woke;

  // Operand state as it will be after this cycle's broadcast.
  always_comb begin
    woke = cell_q;
    if (cell_q.busy && cdb_valid_i) begin
      if (cell_q.qj != '0 && cell_q.qj == cdb_tag_i) begin
        woke.vj = cdb_value_i;
        woke.qj = '0;
      end
      if (cell_q.qk != '0 && cell_q.qk == cdb_tag_i) begin
        woke.vk = cdb_value_i;
        woke.qk = '0;
      end
    end
  end

  always_comb begin
    cell_d = woke;
    if (alloc_we_i) begin
      cell_d      = alloc_cell_i;
      cell_d.busy = 1'b1;
    end else if (issue_clr_i) begin
      cell_d.busy = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)        cell_q      <= '0;
    else if (flush_i) cell_q.busy <= 1'b0;
    else              cell_q      <= cell_d;
  end

  assign busy_o = cell_q.busy;
`ifdef QU_RS_WAKEUP_BYPASS_EN
  assign cell_o = woke;
  assign rdy_o  = woke.busy && woke.qj == '0 && woke.qk == '0;
`else
  assign cell_o = cell_q;
  assign rdy_o  = cell_q.busy && cell_q.qj == '0 && cell_q.qk == '0;
`endif
endmodule

module qu_res_station import qu_res_station_pkg::*; #(
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic                            alloc_valid,
  input  res_st_cell_t                    alloc_cell,
  output logic                            alloc_ready,
  input  logic                            cdb_valid,
  input  logic [TAG_W-1:0]                cdb_tag,
  input  logic [31:0]                     cdb_value,
  output logic                            issue_valid,
  output res_st_cell_t                    issue_cell,
  input  logic                            issue_ready,
  output logic [$clog2(RS_DEPTH+1)-1:0]   occupancy
);
  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int OCC_W = $clog2(RS_DEPTH+1);

  logic [RS_DEPTH-1:0] busy, rdy, alloc_we, issue_clr;
  res_st_cell_t        ent_cell [RS_DEPTH];
  res_st_cell_t        alloc_cap;
  logic [IDX_W-1:0]    free_idx, sel_idx;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic                alloc_fire, issue_fire;

  // A broadcast in the allocation cycle must land in the new entry, or it is lost.
  always_comb begin
    alloc_cap = alloc_cell;
    if (cdb_valid) begin
      if (alloc_cell.qj != '0 && alloc_cell.qj == cdb_tag) begin
        alloc_cap.vj = cdb_value;
        alloc_cap.qj = '0;
      end
      if (alloc_cell.qk != '0 && alloc_cell.qk == cdb_tag) begin
        alloc_cap.vk = cdb_value;
        alloc_cap.qk = '0;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      if (rdy[i])   sel_idx  = IDX_W'(i);
    end
  end

  // alloc_ready comes from the registered count only, so issue_ready never reaches it.
  assign alloc_ready = occ_q < OCC_W'(RS_DEPTH);
  assign issue_valid = |rdy;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_fire  = issue_valid && issue_ready;
  assign occupancy   = occ_q;

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_ent
    assign alloc_we[g]  = alloc_fire && free_idx == IDX_W'(g);
    assign issue_clr[g] = issue_fire && sel_idx  == IDX_W'(g);

    qu_rs_entry #(.TAG_W(TAG_W)) u_ent (
      .clk          (clk),
      .rstn         (rstn),
      .flush_i      (flush),
      .alloc_we_i   (alloc_we[g]),
      .issue_clr_i  (issue_clr[g]),
      .alloc_cell_i (alloc_cap),
      .cdb_valid_i  (cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_value_i  (cdb_value),
      .busy_o       (busy[g]),
      .rdy_o        (rdy[g]),
      .cell_o       (ent_cell[g])
    );
  end

  always_comb begin
    issue_cell = '0;
    if (issue_valid) begin
      issue_cell      = ent_cell[sel_idx];
      issue_cell.qj   = '0;
      issue_cell.qk   = '0;
      issue_cell.busy = 1'b1;
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (alloc_fire && !issue_fire)      occ_d = occ_q + OCC_W'(1);
    else if (!alloc_fire && issue_fire) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn)      occ_q <= '0;
    else if (flush) occ_q <= '0;
    else            occ_q <= occ_d;
  end
endmodule
